// File: rtl/bit_subtractor_parallel_if.sv
// Handshake/operand bundle for bit_subtractor_parallel.
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface bit_subtractor_parallel_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 32
);
   logic                         start;
   logic [LANES-1:0][WIDTH-1:0]  numberA;
   logic [LANES-1:0][WIDTH-1:0]  numberB;
   logic                         bi;
   logic                         busy;
   logic                         ready;
   logic [LANES-1:0][WIDTH-1:0]  diff;
   logic [LANES-1:0]             bo;
`ifdef SUB_OVERFLOW_EN
   logic [LANES-1:0]             ovf;

   modport master (output start, numberA, numberB, bi,
                   input  busy, ready, diff, bo, ovf);
   modport slave  (input  start, numberA, numberB, bi,
                   output busy, ready, diff, bo, ovf);
`else
   modport master (output start, numberA, numberB, bi,
                   input  busy, ready, diff, bo);
   modport slave  (input  start, numberA, numberB, bi,
                   output busy, ready, diff, bo);
`endif
endinterface

// File: rtl/bit_subtractor_parallel.sv
// Multi-lane, multi-cycle subtractor: diff[l] = A[l] - B[l] - bi for every lane.
// Each lane ripples CHUNK bits per clock; a lane's borrow never crosses into
// another lane. Operands are latched on an accepted start, so the inputs are
// free to change while the operation runs.
// Optional feature: define SUB_OVERFLOW_EN to add per-lane signed overflow (ovf).
module bit_subtractor_parallel #(
   parameter int LANES = 4,
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   bit_subtractor_parallel_if.slave bus
);
   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic [CNT_W-1:0]              r_cnt;
   logic [LANES-1:0][WIDTH-1:0]   r_a;
   logic [LANES-1:0][WIDTH-1:0]   r_b;
   logic [LANES-1:0][WIDTH-1:0]   r_diff;
   logic [LANES-1:0]              r_borrow;
   logic [LANES-1:0]              r_bo;
   logic [CHUNK:0]                w_sub [LANES];
   logic [31:0]                   w_base;
   logic                          w_accept;
   logic                          w_last;
`ifdef SUB_OVERFLOW_EN
   logic [LANES-1:0]              r_ovf;
`endif

   // start is honoured only outside RUN; a new request in DONE chains directly
   assign w_accept = bus.start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CNT_W'(N - 1));
   assign w_base   = 32'(r_cnt) * 32'(CHUNK);

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic: IDLE -> RUN -> DONE, with DONE able to restart
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RUN;
         S_RUN:   if (w_last)   w_next = S_DONE;
         S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Per-lane chunk subtract; bit CHUNK of the result is the borrow out of this chunk
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         w_sub[l] = {1'b0, r_a[l][w_base +: CHUNK]}
                  - {1'b0, r_b[l][w_base +: CHUNK]}
                  - {{CHUNK{1'b0}}, r_borrow[l]};
      end
   end

   // Operand latch, chunk sequencing and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_diff   <= '0;
         r_bo     <= '0;
         r_borrow <= '0;
`ifdef SUB_OVERFLOW_EN
         r_ovf    <= '0;
`endif
      end else if (w_accept) begin
         r_a      <= bus.numberA;
         r_b      <= bus.numberB;
         r_borrow <= {LANES{bus.bi}};
         r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
         for (int l = 0; l < LANES; l++) begin
            r_diff[l][w_base +: CHUNK] <= w_sub[l][CHUNK-1:0];
            r_borrow[l]                <= w_sub[l][CHUNK];
         end
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
         if (w_last) begin
            for (int l = 0; l < LANES; l++) begin
               r_bo[l] <= w_sub[l][CHUNK];
`ifdef SUB_OVERFLOW_EN
               // last chunk carries the sign bit, so its top result bit is the diff MSB
               r_ovf[l] <= (r_a[l][WIDTH-1] != r_b[l][WIDTH-1]) &&
                           (w_sub[l][CHUNK-1] != r_a[l][WIDTH-1]);
`endif
            end
         end
      end
   end

   assign bus.busy  = (r_state == S_RUN);
   assign bus.ready = (r_state == S_DONE);
   assign bus.diff  = r_diff;
   assign bus.bo    = r_bo;
`ifdef SUB_OVERFLOW_EN
   assign bus.ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_bit_subtractor_parallel.sv
// Self-checking bench for bit_subtractor_parallel: directed scenarios plus
// randomized operations checked against a whole-word arithmetic model.
module tb_bit_subtractor_parallel;
   localparam int LANES = 4;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int N     = WIDTH / CHUNK;

   typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   bit_subtractor_parallel_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

   bit_subtractor_parallel #(.LANES(LANES), .WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-width subtract; top bit of the WIDTH+1 result is the borrow
   function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic bi);
      return {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      for (int l = 0; l < LANES; l++) v[l] = $urandom;
      return v;
   endfunction

   // Called on a negedge in IDLE/DONE; returns on the negedge of the first RUN cycle
   task automatic start_op(input vec_t a, input vec_t b, input logic bi);
      bus.numberA = a;
      bus.numberB = b;
      bus.bi      = bi;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.numberA = rand_vec();
      bus.numberB = rand_vec();
      bus.bi      = ~bi;
   endtask

   // Waits for ready (lat0 = cycles already elapsed, start cycle = 0) and checks results
   task automatic wait_check(input vec_t a, input vec_t b, input logic bi,
                             input int lat0, input string tag);
      vec_t             ed;
      logic [LANES-1:0] eb;
      logic [LANES-1:0] eo;
      logic [WIDTH:0]   r;
      int               lat;
      for (int l = 0; l < LANES; l++) begin
         r     = ref_sub(a[l], b[l], bi);
         ed[l] = r[WIDTH-1:0];
         eb[l] = r[WIDTH];
         eo[l] = (a[l][WIDTH-1] != b[l][WIDTH-1]) && (r[WIDTH-1] != a[l][WIDTH-1]);
      end
      lat = lat0;
      while (bus.ready !== 1'b1 && lat < 4*N + 10) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(N + 1));
      for (int l = 0; l < LANES; l++)
         check($sformatf("%s diff[%0d]", tag, l), 64'(bus.diff[l]), 64'(ed[l]));
      check({tag, " bo"}, 64'(bus.bo), 64'(eb));
`ifdef SUB_OVERFLOW_EN
      check({tag, " ovf"}, 64'(bus.ovf), 64'(eo));
`else
      if (eo === 'x) check({tag, " ovf model"}, 64'(eo), 64'(0));
`endif
   endtask

   initial begin
      vec_t a1, b1, a2, b2;
      n_checks    = 0;
      n_fails     = 0;
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.numberA = '0;
      bus.numberB = '0;
      bus.bi      = 1'b0;

      // 1. Reset sequence
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset diff",  64'(bus.diff),  64'(0));
      check("reset bo",    64'(bus.bo),    64'(0));
      check("reset ready", 64'(bus.ready), 64'(0));
      check("reset busy",  64'(bus.busy),  64'(0));

      // 2. Basic multi-lane subtract
      a1 = {32'h00000005, 32'h00011001, 32'h20508001, 32'h06000031};
      b1 = {32'h00000003, 32'h00000001, 32'h00508001, 32'h04000031};
      start_op(a1, b1, 1'b0);
      check("basic busy", 64'(bus.busy), 64'(1));
      wait_check(a1, b1, 1'b0, 1, "basic");
      check("basic diff vec", 64'(bus.diff[3]), 64'(32'h00000002));
      check("basic diff l0",  64'(bus.diff[0]), 64'(32'h02000000));
      @(negedge clk);
      check("basic ready pulse", 64'(bus.ready), 64'(0));
      check("basic hold diff2",  64'(bus.diff[2]), 64'(32'h00011000));

      // 3. Wrap-around and borrow-in
      a1 = rand_vec();
      b1 = rand_vec();
      a1[0] = 32'h0;        b1[0] = 32'h1;
      a1[1] = 32'h0000000A; b1[1] = 32'h00000005;
      start_op(a1, b1, 1'b1);
      wait_check(a1, b1, 1'b1, 1, "wrap");
      check("wrap diff0", 64'(bus.diff[0]), 64'(32'hFFFFFFFE));
      check("wrap bo0",   64'(bus.bo[0]),   64'(1));
      check("wrap diff1", 64'(bus.diff[1]), 64'(32'h00000004));
      check("wrap bo1",   64'(bus.bo[1]),   64'(0));
      @(negedge clk);

      // 4. Start during RUN ignored, then back-to-back from DONE
      a1 = rand_vec(); b1 = rand_vec();
      a2 = rand_vec(); b2 = rand_vec();
      start_op(a1, b1, 1'b0);
      @(negedge clk);
      bus.numberA = a2; bus.numberB = b2; bus.bi = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_check(a1, b1, 1'b0, 3, "ignore");
      bus.numberA = a2; bus.numberB = b2; bus.bi = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b busy", 64'(bus.busy), 64'(1));
      wait_check(a2, b2, 1'b1, 1, "b2b");
      @(negedge clk);

      // 5. Reset in the 2nd RUN cycle aborts the operation
      a1 = {4{32'hFFFF_FFFF}};
      b1 = {4{32'h1234_5678}};
      start_op(a1, b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy",  64'(bus.busy),  64'(0));
      check("abort diff",  64'(bus.diff),  64'(0));
      check("abort bo",    64'(bus.bo),    64'(0));
      check("abort ready", 64'(bus.ready), 64'(0));
      for (int i = 0; i < 2*N; i++) begin
         @(negedge clk);
         check("abort no ready", 64'(bus.ready), 64'(0));
      end
      start_op(a1, b1, 1'b0);
      wait_check(a1, b1, 1'b0, 1, "after abort");
      @(negedge clk);

      // 6. Signed overflow corner cases
      a1 = {4{32'h80000000}};
      b1 = {4{32'h00000001}};
      start_op(a1, b1, 1'b0);
      wait_check(a1, b1, 1'b0, 1, "ovf set");
      check("ovf set diff", 64'(bus.diff[2]), 64'(32'h7FFFFFFF));
      check("ovf set bo",   64'(bus.bo),      64'(0));
      @(negedge clk);
      a1 = {4{32'h00000003}};
      start_op(a1, b1, 1'b0);
      wait_check(a1, b1, 1'b0, 1, "ovf clr");
      @(negedge clk);

      // Randomized operations, some issued back-to-back
      for (int i = 0; i < 16; i++) begin
         logic bi_r;
         a1   = rand_vec();
         b1   = rand_vec();
         bi_r = 1'($urandom_range(0, 1));
         if (i % 4 == 0) begin
            a1[i/4] = b1[i/4];
         end
         start_op(a1, b1, bi_r);
         wait_check(a1, b1, bi_r, 1, $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
